cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Synthesizable successor to the CPU simulation monitor. It captures per-cycle or per-fetch CPU trace records (PC, FSM state, ALU result, write strobes) into a parametrised circular buffer.
- Replaces the fixed-time stop with a cycle-limit counter, and adds a stuck-state watchdog.
- After a run, records are drained through a valid/ready read port.
- Sits beside the CPU top, wired to its debug outputs. Used in simulation and on FPGA.

Parameters:
- PC_W, 32, traced PC bits (LSBs of the 64-bit PC)
- DATA_W, 64, traced ALU-output bits
- DEPTH, 16, buffer entries; power of two, at least 2
- MAX_CYCLES, 90, RUN cycles before automatic stop; 0 means no limit
- WDOG_CYCLES, 32, consecutive cycles with unchanged estado before trip; 0 disables the watchdog
- CAP_MODE, 0, 0 = capture every RUN cycle; 1 = capture only when ld_ir_in is high

Ports:
- clock in 1: single clock, rising edge
- reset in 1: asynchronous, active-low
- start in 1: one-cycle pulse; arms a run from IDLE or DONE
- stop in 1: one-cycle pulse; forces the end of a run
- pc_in in 64: CPU PC
- estado_in in 5: CPU control-FSM state
- ula_out_in in 64: ALU result
- mem_wr_in in 1: memory write strobe
- reg_wr_in in 1: register-file write strobe
- ld_ir_in in 1: IR load strobe
- busy out 1: high in RUN
- done out 1: high in DONE
- stop_sim out 1: one-cycle pulse on entry to DONE
- cause out 2: 0 none, 1 LIMIT, 2 WDOG, 3 STOP
- count out $clog2(DEPTH)+1: entries held
- wrapped out 1: sticky; an entry was overwritten in this run
- rd_valid out 1: record available
- rd_ready in 1: consumer accepts
- rd_data out REC_W: oldest record; REC_W = PC_W+5+DATA_W+2 (+32 with timestamps)

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - Pointers, count, cycle counter, watchdog counter, cause and wrapped clear to 0.
  - All outputs are 0; buffer contents are don't-care.
  - Reset low in any state aborts the run immediately.
- Record packing, MSB to LSB: {[ts], pc_in[PC_W-1:0], estado_in, ula_out_in[DATA_W-1:0], mem_wr_in, reg_wr_in}.
- FSM IDLE:
  - start → RUN.
  - stop and rd_ready are ignored.
- FSM RUN (entered on the start edge):
  - Capture condition each cycle: CAP_MODE=0, or ld_ir_in=1.
  - On capture, write the record to buf[wr_ptr] and advance wr_ptr modulo DEPTH.
  - If count<DEPTH, count increments. If count==DEPTH, rd_ptr advances (oldest entry overwritten) and wrapped is set.
  - cyc increments every RUN cycle.
  - Watchdog counter: increments when estado_in equals its previous-cycle value, otherwise clears. The first RUN cycle compares against the value latched at start.
  - start is ignored in RUN.
- RUN → DONE when any of these holds, priority STOP > WDOG > LIMIT:
  - stop;
  - watchdog counter reaches WDOG_CYCLES-1 with an equal compare this cycle;
  - cyc == MAX_CYCLES-1.
- On the terminating cycle:
  - The record is still captured if its capture condition holds.
  - cause is latched.
  - stop_sim pulses high in the first DONE cycle only.
- FSM DONE:
  - rd_valid = (count != 0).
  - rd_data = buf[rd_ptr], combinational show-ahead.
  - rd_valid && rd_ready pops: rd_ptr+1 modulo DEPTH, count-1.
  - rd_ready with rd_valid low has no effect.
  - start clears pointers, count, cyc, watchdog counter, cause and wrapped, then enters RUN; any unread records are discarded.
- Latency: a record captured at edge N is readable from the cycle after edge N.
- Width rules: cyc is 32 bits and saturates at all-ones. Pointers are $clog2(DEPTH) bits.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined: each record carries the 32-bit cyc value at capture in its MSBs, so REC_W grows by 32.
- Undefined: no timestamp field and no extra storage.

Decomposition:
- Package cpu_trace_pkg: state enum {IDLE, RUN, DONE}, cause enum {NONE, LIMIT, WDOG, STOP}, trace record struct, and REC_W computed from the parameters.
- One sub-module, trace_ram: DEPTH×REC_W memory with one synchronous write port and one asynchronous read port.

Test Plan:
- Reset: reset low in mid-RUN with count=5 → next sample shows busy=0, done=0, count=0, cause=0, rd_valid=0.
- Wrap and limit: DEPTH=8, MAX_CYCLES=20, CAP_MODE=0, pc_in=4n on RUN cycle n.
  - After 20 cycles: done=1, cause=LIMIT, stop_sim pulses once, count=8, wrapped=1.
  - Draining yields PCs 48, 52, …, 76.
- Watchdog: WDOG_CYCLES=5, estado_in varying for 3 cycles, then held at 3 → DONE with cause=WDOG exactly 5 cycles after the hold begins.
- Fetch mode and stop: CAP_MODE=1, ld_ir_in high in cycles 1, 4, 7, stop at cycle 9 → cause=STOP, count=3, wrapped=0, records hold the PCs of cycles 1, 4, 7.
- Handshake drain: 4 records, rd_ready toggling 1,0,1,1,0,1 → exactly 4 pops in order, rd_valid falls after the 4th pop, and further rd_ready has no effect.
- TRACE_TIMESTAMP_EN defined: CAP_MODE=0, start, stop at cycle 3 → timestamps 0, 1, 2, 3; start again from DONE → count=0 and the new run's timestamps restart at 0.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared types and record sizing for the CPU trace buffer (TRACE_TIMESTAMP_EN adds a 32-bit timestamp).
package cpu_trace_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {NONE, LIMIT, WDOG, STOP} cause_t;
  localparam int EST_W = 5;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif
  typedef struct packed {
    logic [31:0] pc;
    logic [EST_W-1:0] estado;
    logic [63:0] ula_out;
    logic mem_wr;
    logic reg_wr;
  } trace_rec_t;
  function automatic int rec_w(int pc_w, int data_w);
    return TS_W + pc_w + EST_W + data_w + 2;
  endfunction
endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram: DEPTH x W record store, synchronous write, asynchronous read.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of CPU trace records with cycle limit, stuck-state watchdog and valid/ready drain.
// Define TRACE_TIMESTAMP_EN to prefix each record with the 32-bit cycle count at capture.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH = 16,
  parameter int MAX_CYCLES = 90,
  parameter int WDOG_CYCLES = 32,
  parameter int CAP_MODE = 0,
  localparam int REC_W = rec_w(PC_W, DATA_W),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [63:0]      pc_in,
  input  logic [4:0]       estado_in,
  input  logic [63:0]      ula_out_in,
  input  logic             mem_wr_in,
  input  logic             reg_wr_in,
  input  logic             ld_ir_in,
  output logic             busy,
  output logic             done,
  output logic             stop_sim,
  output logic [1:0]       cause,
  output logic [CW-1:0]    count,
  output logic             wrapped,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data
);
  localparam int PW = $clog2(DEPTH);
  state_t state, state_nx;
  cause_t cause_q, end_cause;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [31:0] cyc, wdog;
  logic [4:0] prev_est;
  logic wrapped_q, stop_sim_q, cap, eq, wd_trip, lim_trip, term, arm, full, pop, unused_bits;
  logic [REC_W-1:0] wdata, rdata;

  assign eq = estado_in == prev_est;
  assign cap = state == RUN && (CAP_MODE == 0 || ld_ir_in);
  assign wd_trip = WDOG_CYCLES != 0 && eq && wdog == 32'(WDOG_CYCLES - 1);
  assign lim_trip = MAX_CYCLES != 0 && cyc == 32'(MAX_CYCLES - 1);
  assign end_cause = stop ? STOP : wd_trip ? WDOG : lim_trip ? LIMIT : NONE;
  assign term = state == RUN && end_cause != NONE;
  assign arm = start && state != RUN;
  assign full = cnt == CW'(DEPTH);
  assign pop = rd_valid && rd_ready;
  assign unused_bits = ^{pc_in, ula_out_in};
`ifdef TRACE_TIMESTAMP_EN
  assign wdata = {cyc, pc_in[PC_W-1:0], estado_in, ula_out_in[DATA_W-1:0], mem_wr_in, reg_wr_in};
`else
  assign wdata = {pc_in[PC_W-1:0], estado_in, ula_out_in[DATA_W-1:0], mem_wr_in, reg_wr_in};
`endif

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = term ? DONE : arm ? RUN : state;
    busy = state == RUN;
    done = state == DONE;
    rd_valid = done && cnt != '0;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      cyc <= '0;
      wdog <= '0;
      prev_est <= '0;
      cause_q <= NONE;
      wrapped_q <= 1'b0;
      stop_sim_q <= 1'b0;
    end else begin
      stop_sim_q <= term;
      if (arm) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
        cyc <= '0;
        wdog <= '0;
        cause_q <= NONE;
        wrapped_q <= 1'b0;
        prev_est <= estado_in;
      end else if (state == RUN) begin
        // a full buffer keeps its size by dropping the oldest entry
        if (cap) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (full) begin
            rd_ptr <= rd_ptr + 1'b1;
            wrapped_q <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        cyc <= &cyc ? cyc : cyc + 1'b1;
        wdog <= eq ? wdog + 1'b1 : '0;
        prev_est <= estado_in;
        if (term) cause_q <= end_cause;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end

  trace_ram #(.DEPTH(DEPTH), .W(REC_W)) u_ram (
    .clock(clock),
    .we(cap),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  assign rd_data = rd_valid ? rdata : '0;
  assign cause = cause_q;
  assign count = cnt;
  assign wrapped = wrapped_q;
  assign stop_sim = stop_sim_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed tests of capture, wrap, limit, watchdog, fetch mode, drain handshake and timestamps.
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;
  localparam int PC_W = 32, DATA_W = 64, DEPTH = 8, CW = 4;
  localparam int REC_W = rec_w(PC_W, DATA_W);
  localparam int BASE_W = PC_W + 5 + DATA_W + 2;

  logic clock = 1'b0, reset = 1'b1, start_a = 1'b0, start_b = 1'b0, stop = 1'b0;
  logic [63:0] pc_in = '0, ula_out_in = '0;
  logic [4:0] estado_in = '0;
  logic mem_wr_in = 1'b0, reg_wr_in = 1'b0, ld_ir_in = 1'b0, rd_ready = 1'b0;
  logic busy_a, done_a, stop_sim_a, wrapped_a, rd_valid_a, busy_b, done_b, stop_sim_b, wrapped_b, rd_valid_b;
  logic [1:0] cause_a, cause_b;
  logic [CW-1:0] count_a, count_b;
  logic [REC_W-1:0] rd_data_a, rd_data_b;
  logic [10:0] st_a, st_b, exp_st;
  logic [BASE_W-1:0] exp_rec;
  int checks = 0, fails = 0;

  always #5 clock = ~clock;

  cpu_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_CYCLES(20), .WDOG_CYCLES(5), .CAP_MODE(0)) u_a (
    .clock(clock), .reset(reset), .start(start_a), .stop(stop), .pc_in(pc_in), .estado_in(estado_in),
    .ula_out_in(ula_out_in), .mem_wr_in(mem_wr_in), .reg_wr_in(reg_wr_in), .ld_ir_in(ld_ir_in),
    .busy(busy_a), .done(done_a), .stop_sim(stop_sim_a), .cause(cause_a), .count(count_a),
    .wrapped(wrapped_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a));

  cpu_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_CYCLES(0), .WDOG_CYCLES(0), .CAP_MODE(1)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .stop(stop), .pc_in(pc_in), .estado_in(estado_in),
    .ula_out_in(ula_out_in), .mem_wr_in(mem_wr_in), .reg_wr_in(reg_wr_in), .ld_ir_in(ld_ir_in),
    .busy(busy_b), .done(done_b), .stop_sim(stop_sim_b), .cause(cause_b), .count(count_b),
    .wrapped(wrapped_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b));

  assign st_a = {busy_a, done_a, stop_sim_a, cause_a, count_a, wrapped_a, rd_valid_a};
  assign st_b = {busy_b, done_b, stop_sim_b, cause_b, count_b, wrapped_b, rd_valid_b};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (st_a !== 11'b0) begin fails++; $display("FAIL reset_a: got %b expected %b", st_a, 11'b0); end
    checks++;
    if (st_b !== 11'b0) begin fails++; $display("FAIL reset_b: got %b expected %b", st_b, 11'b0); end
    reset = 1'b1;
    stop = 1'b1;
    rd_ready = 1'b1;
    step();
    stop = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (st_a !== 11'b0) begin fails++; $display("FAIL idle_ignores_stop: got %b expected %b", st_a, 11'b0); end
    estado_in = 5'd31;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 0; n < 5; n++) begin
      estado_in = 5'(n + 1);
      pc_in = 64'(n);
      step();
    end
    exp_st = {1'b1, 1'b0, 1'b0, 2'd0, 4'd5, 1'b0, 1'b0};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL run_count5: got %b expected %b", st_a, exp_st); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (st_a !== 11'b0) begin fails++; $display("FAIL reset_midrun: got %b expected %b", st_a, 11'b0); end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_wrap_limit();
    estado_in = 5'd31;
    start_a = 1'b1;
    step();
    for (int n = 0; n < 20; n++) begin
      start_a = (n == 10);
      pc_in = 64'(4 * n);
      estado_in = 5'(n);
      ula_out_in = 64'(3 * n);
      mem_wr_in = n[0];
      reg_wr_in = n[1];
      if (n == 19) begin
        exp_st = {1'b1, 1'b0, 1'b0, 2'd0, 4'd8, 1'b1, 1'b0};
        checks++;
        if (st_a !== exp_st) begin fails++; $display("FAIL before_limit: got %b expected %b", st_a, exp_st); end
      end
      step();
    end
    start_a = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b1, 2'd1, 4'd8, 1'b1, 1'b1};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL limit_done: got %b expected %b", st_a, exp_st); end
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 2'd1, 4'd8, 1'b1, 1'b1};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL stop_sim_once: got %b expected %b", st_a, exp_st); end
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = 12 + k;
      exp_rec = {32'(48 + 4 * k), 5'(n), 64'(3 * n), n[0], n[1]};
      checks++;
      if (rd_data_a[BASE_W-1:0] !== exp_rec) begin
        fails++;
        $display("FAIL wrap_drain[%0d]: got %h expected %h", k, rd_data_a[BASE_W-1:0], exp_rec);
      end
      step();
    end
    rd_ready = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 2'd1, 4'd0, 1'b1, 1'b0};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL wrap_drained: got %b expected %b", st_a, exp_st); end
  endtask

  task automatic test_watchdog();
    estado_in = 5'd31;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 0; n < 9; n++) begin
      estado_in = (n == 0) ? 5'd1 : (n == 1) ? 5'd2 : (n == 2) ? 5'd4 : 5'd3;
      pc_in = 64'(n);
      step();
      if (n == 7) begin
        checks++;
        if ({busy_a, done_a} !== 2'b10) begin fails++; $display("FAIL wdog_early: got %b expected %b", {busy_a, done_a}, 2'b10); end
      end
    end
    exp_st = {1'b0, 1'b1, 1'b1, 2'd2, 4'd8, 1'b1, 1'b1};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL wdog_trip: got %b expected %b", st_a, exp_st); end
  endtask

  task automatic test_fetch_stop();
    estado_in = 5'd31;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int n = 0; n < 10; n++) begin
      pc_in = 64'(100 + n);
      estado_in = 5'(n);
      ld_ir_in = (n == 1 || n == 4 || n == 7);
      stop = (n == 9);
      step();
    end
    stop = 1'b0;
    ld_ir_in = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b1, 2'd3, 4'd3, 1'b0, 1'b1};
    checks++;
    if (st_b !== exp_st) begin fails++; $display("FAIL fetch_stop: got %b expected %b", st_b, exp_st); end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_data_b[DATA_W+7 +: PC_W] !== 32'(101 + 3 * k)) begin
        fails++;
        $display("FAIL fetch_pc[%0d]: got %0d expected %0d", k, rd_data_b[DATA_W+7 +: PC_W], 101 + 3 * k);
      end
      step();
    end
    rd_ready = 1'b0;
    checks++;
    if (rd_valid_b !== 1'b0) begin fails++; $display("FAIL fetch_empty: got %b expected 0", rd_valid_b); end
  endtask

  task automatic test_back_to_back();
    int rdy[6] = '{1, 0, 1, 1, 0, 1};
    int idx = 0;
    estado_in = 5'd31;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    exp_st = {1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL restart_clear: got %b expected %b", st_a, exp_st); end
    for (int n = 0; n < 4; n++) begin
      pc_in = 64'(200 + n);
      estado_in = 5'(n + 7);
      stop = (n == 3);
      step();
    end
    stop = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b1, 2'd3, 4'd4, 1'b0, 1'b1};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL hs_filled: got %b expected %b", st_a, exp_st); end
    for (int i = 0; i < 6; i++) begin
      rd_ready = rdy[i][0];
      checks++;
      if (rd_valid_a !== (idx < 4)) begin fails++; $display("FAIL hs_valid[%0d]: got %b expected %b", i, rd_valid_a, idx < 4); end
      if (idx < 4) begin
        checks++;
        if (rd_data_a[DATA_W+7 +: PC_W] !== 32'(200 + idx)) begin
          fails++;
          $display("FAIL hs_pc[%0d]: got %0d expected %0d", i, rd_data_a[DATA_W+7 +: PC_W], 200 + idx);
        end
      end
      step();
      if (rdy[i] != 0 && idx < 4) idx++;
    end
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0};
    checks++;
    if (st_a !== exp_st) begin fails++; $display("FAIL hs_empty: got %b expected %b", st_a, exp_st); end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    for (int r = 0; r < 2; r++) begin
      int last;
      last = (r == 0) ? 3 : 1;
      estado_in = 5'd31;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      checks++;
      if (count_a !== 4'd0) begin fails++; $display("FAIL ts_start_count[%0d]: got %0d expected 0", r, count_a); end
      for (int n = 0; n <= last; n++) begin
        pc_in = 64'(n);
        estado_in = 5'(n + 1);
        stop = (n == last);
        step();
      end
      stop = 1'b0;
      rd_ready = 1'b1;
      for (int k = 0; k <= last; k++) begin
        checks++;
        if (rd_data_a[REC_W-1 -: 32] !== 32'(k)) begin
          fails++;
          $display("FAIL ts[%0d][%0d]: got %0d expected %0d", r, k, rd_data_a[REC_W-1 -: 32], k);
        end
        step();
      end
      rd_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap_limit();
    test_watchdog();
    test_fetch_stop();
    test_back_to_back();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
